bram_stream_reader: RTL and testbench
=====================================

# bram_stream_reader

Reads a stored vector out of the BRAM_A/BRAM_B read port one byte at a time and hands each byte to the UART transmitter, waiting for the transmitter's completion flag before fetching the next byte. It is the read-back counterpart of the UART-to-BRAM loader. A host can dump a loaded vector and compare it byte-for-byte with what it sent. It sits between the two BRAM read ports and `output_interface`'s serial byte input, on the 100 MHz system clock.

## Interface
- `NBytes`, 1024: vector length in bytes; bytes sent per dump.
- `ADDR_W`, 10: BRAM address width; NBytes ≤ 2^ADDR_W.

- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `start`  input  1  dump request; sampled only in IDLE.
- `sel`  input  1  vector select, sampled with `start`: 0 = BRAM_A, 1 = BRAM_B.
- `bramA_byte`  input  8  BRAM_A read data; registered read, valid 1 cycle after address.
- `bramB_byte`  input  8  BRAM_B read data; same timing.
- `tx_flag`  input  1  one-cycle pulse: the transmitter finished the current byte.
- `bram_addr`  output  ADDR_W  BRAM read address.
- `tx_data`  output  8  byte to transmit; held stable from `tx_start` until `tx_flag`.
- `tx_start`  output  1  one-cycle pulse: transmit `tx_data`.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse: dump complete.

## Operation
- States: IDLE, FETCH, SEND, WAIT_TX, CSUM (checksum build only), DONE.
- IDLE: `bram_addr`=0. On `start`=1, latch `sel`, clear byte counter and checksum, and go to FETCH.
- FETCH: hold `bram_addr` for one cycle so the BRAM output settles. Then go to SEND.
- SEND: register the selected BRAM byte into `tx_data`, add it to the checksum (mod 256), pulse `tx_start`, and go to WAIT_TX.
- WAIT_TX: wait for `tx_flag`.
  - On `tx_flag` with counter < NBytes-1: increment the counter and `bram_addr`, then go to FETCH.
  - On `tx_flag` with counter = NBytes-1: go to CSUM if the checksum is compiled in, else DONE.
- CSUM: `tx_data` = checksum. Pulse `tx_start`, wait for `tx_flag`, then go to DONE.
- DONE: pulse `done` for one cycle, return `bram_addr` to 0, and go to IDLE.
- Boundary rules:
  - `start` outside IDLE is ignored. A dump cannot be restarted or re-targeted mid-stream.
  - `tx_flag` outside WAIT_TX/CSUM-wait is ignored. No byte is skipped or duplicated.
  - `tx_flag` coincident with `tx_start` (the SEND cycle) is ignored. Only flags after SEND count.
  - `start` in the DONE cycle is ignored. `start` in the next IDLE cycle is accepted.
  - `bram_addr` never exceeds NBytes-1. There is no wrap mid-dump; it resets to 0 only in DONE or IDLE.
  - Reset asserted mid-dump aborts immediately with no `done` pulse. Any partially sent UART byte is the transmitter's concern.
- Reset values: `bram_addr`=0, `tx_data`=8'h00, `tx_start`=0, `busy`=0, `done`=0, state IDLE.

## Timing
- All outputs are registered.
- `start` sampled at edge E0 → `busy` high after E0 → `tx_start` high for the cycle after E2, carrying byte 0.
- `tx_flag` sampled at edge F0 → next `tx_start` high for the cycle after F2 (FETCH + SEND).
- `tx_flag` for the last data byte at edge L0:
  - Without checksum: `done` high for the cycle after L1, and `busy` falls after L2.
  - With checksum: checksum `tx_start` comes 1 cycle after L0.
- Per-byte overhead beyond UART time: 2 cycles.

## Configuration
- `STREAM_CHECKSUM_EN` defined: after the NBytes data bytes, one extra byte is sent, equal to the 8-bit sum mod 256 of all data bytes. A dump is NBytes+1 UART bytes.
- Not defined: the CSUM state and checksum register are absent. A dump is exactly NBytes bytes, and `done` follows the last data byte's `tx_flag`.

## Test plan
- BRAM_A preloaded with addr[7:0]; `sel`=0, `start`; transmitter model returns `tx_flag` 5 cycles after each `tx_start` → 1024 `tx_start` pulses, `tx_data` = 0x00,0x01,…,0xFF repeating, then one `done` pulse, then `busy`=0.
- BRAM_B all 0xA5, BRAM_A all 0x00, `sel`=1 → every `tx_data`=0xA5. With `STREAM_CHECKSUM_EN`, the 1025th byte = (1024·0xA5) mod 256 = 0x00.
- NBytes=4, BRAM_A = 0x10,0x20,0x30,0x45, checksum enabled → bytes 0x10,0x20,0x30,0x45,0xA5, then `done`.
- `start` re-pulsed and `sel` toggled during byte 3; spurious `tx_flag` during FETCH → sequence and target vector unchanged, no byte skipped.
- Reset low for 1 cycle while waiting for byte 500's `tx_flag` → all outputs at reset values next cycle, no `done`. A new `start` then begins again at address 0.
- Latency check: `start` at edge E0 → `tx_start` high exactly the cycle after E2; `tx_flag` at F0 → next `tx_start` exactly the cycle after F2.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Streams NBytes from the selected BRAM read port to the UART transmitter, one byte per tx_flag.
// Optional trailing 8-bit checksum byte when STREAM_CHECKSUM_EN is defined.
module bram_stream_reader #(
    parameter int NBytes = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sel,
    input  logic [7:0]        bramA_byte,
    input  logic [7:0]        bramB_byte,
    input  logic              tx_flag,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              done
);

`ifdef STREAM_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND, S_WAIT_TX, S_CSUM, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND, S_WAIT_TX, S_DONE
    } state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBytes - 1);

    state_t            r_state, w_state_next;
    logic              r_sel, w_sel_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [7:0]        r_tx_data, w_tx_data_next;
    logic              r_tx_start, w_tx_start_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic [7:0]        w_bram_byte;
    logic              w_flag;
`ifdef STREAM_CHECKSUM_EN
    logic [7:0]        r_csum, w_csum_next;
`endif

    assign w_bram_byte = r_sel ? bramB_byte : bramA_byte;
    // A flag arriving in the same cycle as our own tx_start belongs to no byte of ours.
    assign w_flag      = tx_flag && !r_tx_start;

    always_comb begin
        w_state_next    = r_state;
        w_sel_next      = r_sel;
        w_addr_next     = r_addr;
        w_tx_data_next  = r_tx_data;
        w_tx_start_next = 1'b0;
        w_done_next     = 1'b0;
`ifdef STREAM_CHECKSUM_EN
        w_csum_next     = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                w_addr_next = '0;
                if (start) begin
                    w_sel_next   = sel;
`ifdef STREAM_CHECKSUM_EN
                    w_csum_next  = 8'h00;
`endif
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_SEND;
            end
            S_SEND: begin
                w_tx_data_next  = w_bram_byte;
                w_tx_start_next = 1'b1;
`ifdef STREAM_CHECKSUM_EN
                w_csum_next     = r_csum + w_bram_byte;
`endif
                w_state_next    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (w_flag) begin
                    if (r_addr == LAST_ADDR) begin
`ifdef STREAM_CHECKSUM_EN
                        w_tx_data_next  = r_csum;
                        w_tx_start_next = 1'b1;
                        w_state_next    = S_CSUM;
`else
                        w_state_next    = S_DONE;
`endif
                    end else begin
                        w_addr_next  = r_addr + ADDR_W'(1);
                        w_state_next = S_FETCH;
                    end
                end
            end
`ifdef STREAM_CHECKSUM_EN
            S_CSUM: begin
                if (w_flag) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_done_next  = 1'b1;
                w_addr_next  = '0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // busy stays up through the done pulse and drops the cycle after it.
        w_busy_next = (w_state_next != S_IDLE) || (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b0;
            r_addr     <= '0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef STREAM_CHECKSUM_EN
            r_csum     <= 8'h00;
`endif
        end else begin
            r_state    <= w_state_next;
            r_sel      <= w_sel_next;
            r_addr     <= w_addr_next;
            r_tx_data  <= w_tx_data_next;
            r_tx_start <= w_tx_start_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
`ifdef STREAM_CHECKSUM_EN
            r_csum     <= w_csum_next;
`endif
        end
    end

    assign bram_addr = r_addr;
    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomised bench for bram_stream_reader: byte-queue reference model plus cycle-exact latency checks.
module tb_bram_stream_reader;

    localparam int N  = 1024;
    localparam int AW = 10;
`ifdef STREAM_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int BIG = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sel;
    logic [7:0]    bramA_byte;
    logic [7:0]    bramB_byte;
    logic          tx_flag;
    logic [AW-1:0] bram_addr;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          busy;
    logic          done;

    logic [7:0] memA [N];
    logic [7:0] memB [N];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    logic [7:0] expq [$];
    logic [7:0] got  [$];
    logic [7:0] hold_byte = 8'h00;
    bit         active = 0;
    bit         outstanding = 0;
    bit         chk_reset = 0;
    int         byte_idx = 0;
    int         dumps_done = 0;
    int         exp_tx_cyc = -1;
    int         exp_done_cyc = -1;
    int         busy_on = BIG;
    int         busy_off = BIG;

    bram_stream_reader #(.NBytes(N), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sel        (sel),
        .bramA_byte (bramA_byte),
        .bramB_byte (bramB_byte),
        .tx_flag    (tx_flag),
        .bram_addr  (bram_addr),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        bramA_byte <= memA[bram_addr];
        bramB_byte <= memB[bram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitter: flag 1..5 cycles after each tx_start, random spurious flags when nothing is in flight.
    initial begin : xmit
        int cnt;
        cnt = -1;
        tx_flag = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_flag = 1'b0;
            if (tx_start) begin
                cnt = $urandom_range(1, 5);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_flag = 1'b1;
                    cnt = -1;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                tx_flag = 1'b1;
            end
        end
    end

    // Compare process: outputs seen this cycle are checked first, then inputs update the model.
    initial begin : compare
        logic [7:0] e;
        logic [7:0] sum;
        forever begin
            @(negedge clk);
            if (chk_reset) begin
                check("rst_addr", 32'(bram_addr), 0);
                check("rst_tx_data", 32'(tx_data), 0);
                check("rst_tx_start", 32'(tx_start), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_done", 32'(done), 0);
                chk_reset = 0;
            end
            check("addr_bound", 32'(bram_addr <= AW'(N - 1)), 1);
            if (tx_start) begin
                check("tx_start_timing", cyc, exp_tx_cyc);
                exp_tx_cyc = -1;
                if (expq.size() == 0) begin
                    check("tx_unexpected", 32'(tx_data), 32'hffff_ffff);
                end else begin
                    e = expq.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e));
                end
                if (byte_idx < N) check("addr_at_tx", 32'(bram_addr), byte_idx);
                got.push_back(tx_data);
                hold_byte   = tx_data;
                byte_idx++;
                outstanding = 1;
            end else if (cyc == exp_tx_cyc) begin
                check("tx_start_missing", 0, 1);
                exp_tx_cyc = -1;
            end else if (outstanding) begin
                check("tx_data_hold", 32'(tx_data), 32'(hold_byte));
            end
            check("done", 32'(done), 32'(cyc == exp_done_cyc));
            check("busy", 32'(busy), 32'(cyc >= busy_on && cyc < busy_off));
            if (cyc == exp_done_cyc) begin
                check("addr_after_done", 32'(bram_addr), 0);
                check("bytes_left", expq.size(), 0);
                $display("dump %0d complete: %0d bytes, last byte %02h", dumps_done + 1, got.size(),
                         (got.size() > 0) ? got[got.size() - 1] : 8'h00);
                active       = 0;
                exp_done_cyc = -1;
                dumps_done++;
            end
            if (!reset) begin
                expq.delete();
                active       = 0;
                outstanding  = 0;
                exp_tx_cyc   = -1;
                exp_done_cyc = -1;
                busy_on      = BIG;
                busy_off     = cyc + 1;
                chk_reset    = 1;
            end else begin
                if (tx_flag && outstanding) begin
                    outstanding = 0;
                    if (byte_idx < N) begin
                        exp_tx_cyc = cyc + 3;
                    end else if (byte_idx == N && CK == 1) begin
                        exp_tx_cyc = cyc + 1;
                    end else begin
                        exp_done_cyc = cyc + 2;
                        busy_off     = cyc + 3;
                    end
                end
                if (start && !active) begin
                    active = 1;
                    expq.delete();
                    got.delete();
                    sum = 8'h00;
                    for (int i = 0; i < N; i++) begin
                        e = sel ? memB[i] : memA[i];
                        expq.push_back(e);
                        sum = sum + e;
                    end
                    if (CK == 1) expq.push_back(sum);
                    byte_idx   = 0;
                    exp_tx_cyc = cyc + 3;
                    busy_on    = cyc + 1;
                    busy_off   = BIG;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic s);
        start = 1'b1;
        sel   = s;
        step();
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int k;
        k = 0;
        while (byte_idx < n && k < 20000) begin
            step();
            k++;
        end
        check("bytes_timeout", 32'(byte_idx >= n), 1);
    endtask

    task automatic wait_done(input int prev);
        int k;
        k = 0;
        while (dumps_done == prev && k < 20000) begin
            step();
            k++;
        end
        check("done_timeout", 32'(dumps_done != prev), 1);
    endtask

    initial begin : stim
        int prev;
        reset = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        for (int i = 0; i < N; i++) begin
            memA[i] = 8'(i);
            memB[i] = 8'($urandom);
        end
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();

        // Dump 1: counting pattern from A, with a re-start and sel toggle during byte 3.
        prev = dumps_done;
        do_start(1'b0);
        wait_bytes(4);
        start = 1'b1;
        sel   = 1'b1;
        step();
        start = 1'b0;
        wait_done(prev);
        check("d1_count", got.size(), N + CK);
        check("d1_b0", 32'(got[0]), 32'h00);
        check("d1_b1", 32'(got[1]), 32'h01);
        check("d1_b255", 32'(got[255]), 32'hff);
        check("d1_b256", 32'(got[256]), 32'h00);
        check("d1_b1023", 32'(got[1023]), 32'hff);
        if (CK == 1) check("d1_csum", 32'(got[N]), 32'h00);
        step();

        // Dump 2: B all A5, A all zero, select B.
        for (int i = 0; i < N; i++) begin
            memA[i] = 8'h00;
            memB[i] = 8'ha5;
        end
        prev = dumps_done;
        do_start(1'b1);
        wait_done(prev);
        check("d2_count", got.size(), N + CK);
        check("d2_b7", 32'(got[7]), 32'ha5);
        check("d2_b1023", 32'(got[1023]), 32'ha5);
        if (CK == 1) check("d2_csum", 32'(got[N]), 32'h00);

        // Dump 3: random A, aborted by reset while byte 500 is in flight.
        for (int i = 0; i < N; i++) memA[i] = 8'($urandom);
        prev = dumps_done;
        do_start(1'b0);
        wait_bytes(501);
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (12) step();
        check("abort_no_done", dumps_done, prev);

        // Dump 4: restart from address 0 on the same vector.
        do_start(1'b0);
        wait_done(prev);
        check("d4_count", got.size(), N + CK);
        check("d4_b0", 32'(got[0]), 32'(memA[0]));

        // Dump 5: random B, immediately back-to-back start after done.
        for (int i = 0; i < N; i++) memB[i] = 8'($urandom);
        prev = dumps_done;
        do_start(1'b1);
        wait_done(prev);
        check("d5_count", got.size(), N + CK);

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
